seqmpy: RTL

- Sequential shift-add 32x32 multiplier that responds to the ALU's multiply request interface: `i_stb`/`i_op` in, `o_busy`/`o_valid`/`o_result`/`o_hi` out.
- Used in place of the DSP-based multiplier on small-fabric builds; trades latency (up to 34 clocks) for area (one 64-bit accumulator and a 32-bit adder).
- Handles MPY, MPYHU and MPYHS using the ALU's 2-bit multiply op encoding.

---
 rtl/seqmpy.sv | 105 ++++++++++
 1 files changed

// File: rtl/seqmpy.sv
// Sequential shift-add 32x32 multiplier (MPY / MPYHU / MPYHS), one partial product per clock.
// Optional macro SEQMPY_EARLY_EXIT_EN: stop once the remaining multiplier bits are zero.
module seqmpy #(
  parameter logic OPT_LOWPOWER = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  output logic        o_busy,
  output logic [63:0] o_result,
  output logic        o_hi
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [5:0]  cnt;
  logic        sgn;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] step_sum;
  logic [63:0] step_acc;
  logic [31:0] mb_shift;
  logic        run_done;
  logic [63:0] aligned;
  logic [63:0] final_val;

  // Signed ops work on magnitudes; the sign is reapplied in FIN.
  assign abs_a = (i_op[0] && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign abs_b = (i_op[0] && i_b[31]) ? (~i_b + 32'd1) : i_b;

  assign step_sum = {1'b0, acc[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
  assign step_acc = {step_sum, acc[31:1]};
  assign mb_shift = {1'b0, mb[31:1]};

`ifdef SEQMPY_EARLY_EXIT_EN
  assign run_done = (cnt == 6'd31) || (mb_shift == 32'd0);
  // cnt holds the number of steps taken; skipped steps would only have shifted right.
  assign aligned  = acc >> (6'd32 - cnt);
`else
  assign run_done = (cnt == 6'd31);
  assign aligned  = acc;
`endif

  assign final_val = sgn ? (~aligned + 64'd1) : aligned;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      acc      <= 64'd0;
      ma       <= 32'd0;
      mb       <= 32'd0;
      cnt      <= 6'd0;
      sgn      <= 1'b0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_result <= 64'd0;
      o_hi     <= 1'b0;
    end else begin
      o_valid  <= 1'b0;
      o_result <= OPT_LOWPOWER ? 64'd0 : acc;
      case (state)
        IDLE: begin
          if (i_stb) begin
            sgn    <= i_op[0] & (i_a[31] ^ i_b[31]);
            o_hi   <= i_op[1];
            ma     <= abs_a;
            mb     <= abs_b;
            acc    <= 64'd0;
            cnt    <= 6'd0;
            o_busy <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= step_acc;
          mb  <= mb_shift;
          cnt <= cnt + 6'd1;
          if (run_done)
            state <= FIN;
        end
        FIN: begin
          acc      <= final_val;
          o_result <= final_val;
          o_valid  <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
